// File: rtl/counter_sched.sv
// counter_sched
//   Shares one external WIDTH-bit down-counter between two requesters.
//   The granted requester's start value is loaded into the counter. The
//   counter is then stepped down once every PRESCALE clocks until its zero
//   flag rises. The winner then gets a one-cycle done pulse.
//   Simultaneous requests are arbitrated round-robin; after reset req0 wins.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active-low
//   req0 / req1         requester wants a countdown (level)
//   val0 / val1         requester start value, sampled in IDLE at grant
//   gnt0 / gnt1         requester owns the counter (LOAD through DONE)
//   done0 / done1       one-cycle completion pulse for the requester
//   busy                controller is not idle
//   cnt_in              value presented to the counter IN
//   cnt_latch           counter loads cnt_in on the next edge
//   cnt_dec             counter decrements on the next edge
//   cnt_zero            counter zero flag from the counter

module counter_sched #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] val0,
  input  logic             req1,
  input  logic [WIDTH-1:0] val1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_latch,
  output logic             cnt_dec,
  input  logic             cnt_zero
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             win_q, win_d;         // 1: requester 1 owns the counter
  logic             prio1_q, prio1_d;     // 1: requester 1 wins a tie
  logic [PW-1:0]    p_q, p_d;             // prescale phase within RUN
  logic [WIDTH-1:0] cnt_in_q, cnt_in_d;   // doubles as the registered start value
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             cnt_latch_q, cnt_latch_d;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    prio1_d  = prio1_q;
    p_d      = p_q;
    cnt_in_d = cnt_in_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // A lone requester always wins; on a tie the pointer decides.
          win_d    = req1 && (!req0 || prio1_q);
          cnt_in_d = win_d ? val1 : val0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        p_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        end
      end
      S_DONE: begin
        // Next tie goes to the requester that was not just served.
        prio1_d = !win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    gnt0_d      = busy_d && !win_d;
    gnt1_d      = busy_d && win_d;
    cnt_latch_d = (state_d == S_LOAD);
    done0_d     = (state_d == S_DONE) && !win_d;
    done1_d     = (state_d == S_DONE) && win_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      prio1_q     <= 1'b0;
      p_q         <= '0;
      cnt_in_q    <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      prio1_q     <= prio1_d;
      p_q         <= p_d;
      cnt_in_q    <= cnt_in_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
      cnt_latch_q <= cnt_latch_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign cnt_in    = cnt_in_q;
  assign cnt_latch = cnt_latch_q;

  // The step must see the live zero flag so the counter never wraps below 0.
  // For that reason this output is decoded from registered state and is not a flop.
  assign cnt_dec = (state_q == S_RUN) && (p_q == P_LAST) && !cnt_zero;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched
//   Drives two counter_sched instances from shared requests. Instance A uses
//   PRESCALE=1 and instance B uses PRESCALE=4. Each instance has its own
//   behavioural down-counter.

module tb_counter_sched;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] val0, val1;

  logic         a_gnt0, a_gnt1, a_done0, a_done1, a_busy, a_latch, a_dec, a_zero;
  logic [W-1:0] a_cin;
  logic         b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_latch, b_dec, b_zero;
  logic [W-1:0] b_cin;

  logic [W-1:0] a_cnt = '0;
  logic [W-1:0] b_cnt = '0;

  int checks = 0;
  int errors = 0;

  counter_sched #(.WIDTH(W), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
    .busy(a_busy), .cnt_in(a_cin), .cnt_latch(a_latch), .cnt_dec(a_dec),
    .cnt_zero(a_zero)
  );

  counter_sched #(.WIDTH(W), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
    .busy(b_busy), .cnt_in(b_cin), .cnt_latch(b_latch), .cnt_dec(b_dec),
    .cnt_zero(b_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External counters; their content survives the controller reset.
  always @(posedge clk) begin
    if (a_latch) a_cnt <= a_cin;
    else if (a_dec) a_cnt <= a_cnt - 1'b1;
    if (b_latch) b_cnt <= b_cin;
    else if (b_dec) b_cnt <= b_cnt - 1'b1;
  end
  assign a_zero = (a_cnt == '0);
  assign b_zero = (b_cnt == '0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Continuous invariants, sampled mid-cycle.
  logic a_d0_p = 1'b0, a_d1_p = 1'b0, b_d0_p = 1'b0, b_d1_p = 1'b0;
  always @(posedge clk) begin
    a_d0_p <= a_done0; a_d1_p <= a_done1;
    b_d0_p <= b_done0; b_d1_p <= b_done1;
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("a_latch_and_dec", int'(a_latch & a_dec), 0);
      chk("b_latch_and_dec", int'(b_latch & b_dec), 0);
      chk("a_gnt_both", int'(a_gnt0 & a_gnt1), 0);
      chk("b_gnt_both", int'(b_gnt0 & b_gnt1), 0);
      chk("a_done_width", int'((a_done0 & a_d0_p) | (a_done1 & a_d1_p)), 0);
      chk("b_done_width", int'((b_done0 & b_d0_p) | (b_done1 & b_d1_p)), 0);
      chk("a_ctl_when_idle", int'((a_latch | a_dec) & ~a_busy), 0);
      chk("b_ctl_when_idle", int'((b_latch | b_dec) & ~b_busy), 0);
    end
  end

  typedef struct {
    logic         r0;
    logic [W-1:0] v0;
    logic         r1;
    logic [W-1:0] v1;
    int           win;   // expected winner
    int           v;     // expected start value
  } vec_t;

  vec_t tbl[7];

  // One request pulse, then follow both instances to completion.
  task automatic run_vec(input vec_t t, input int idx);
    int n, na, nb, deca, decb;
    int exp_gnt;
    exp_gnt = (t.win == 1) ? 2 : 1;
    req0 = t.r0; val0 = t.v0; req1 = t.r1; val1 = t.v1;
    n = 0; na = -1; nb = -1; deca = 0; decb = 0;
    while ((na < 0 || nb < 0) && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("load_latch_a", int'(a_latch), 1);
        chk("load_latch_b", int'(b_latch), 1);
        chk("load_cin_a", int'(a_cin), t.v);
        chk("load_cin_b", int'(b_cin), t.v);
        chk("load_gnt_a", int'({a_gnt1, a_gnt0}), exp_gnt);
        chk("load_gnt_b", int'({b_gnt1, b_gnt0}), exp_gnt);
        req0 = 1'b0;
        req1 = 1'b0;
      end
      deca += int'(a_dec);
      decb += int'(b_dec);
      if (na < 0 && (a_done0 || a_done1)) begin
        na = n;
        chk("done_who_a", int'({a_done1, a_done0}), exp_gnt);
        chk("done_gnt_a", int'({a_gnt1, a_gnt0}), exp_gnt);
      end
      if (nb < 0 && (b_done0 || b_done1)) begin
        nb = n;
        chk("done_who_b", int'({b_done1, b_done0}), exp_gnt);
      end
    end
    chk("latency_a", na, 3 + t.v);
    chk("latency_b", nb, 3 + 4 * t.v);
    chk("decs_a", deca, t.v);
    chk("decs_b", decb, t.v);
    @(negedge clk);
    chk("idle_busy_a", int'(a_busy), 0);
    chk("idle_busy_b", int'(b_busy), 0);
    chk("idle_gnt_a", int'({a_gnt1, a_gnt0}), 0);
    chk("cin_hold_a", int'(a_cin), t.v);
    $display("vec %0d: winner=%0d value=%0d done_a@%0d done_b@%0d decs_a=%0d decs_b=%0d",
             idx, t.win, t.v, na, nb, deca, decb);
  endtask

  initial begin
    int n, ng, nd, dec_a;
    int g[3];
    int load_n[3];
    int done_n[3];
    int decs[3];
    int nd5;
    logic val_changed;

    tbl[0] = '{r0: 1'b1, v0: 4'd7,  r1: 1'b0, v1: 4'd3, win: 0, v: 7};
    tbl[1] = '{r0: 1'b0, v0: 4'd5,  r1: 1'b1, v1: 4'd0, win: 1, v: 0};
    tbl[2] = '{r0: 1'b1, v0: 4'd2,  r1: 1'b1, v1: 4'd9, win: 0, v: 2};
    tbl[3] = '{r0: 1'b1, v0: 4'd4,  r1: 1'b1, v1: 4'd3, win: 1, v: 3};
    tbl[4] = '{r0: 1'b1, v0: 4'd15, r1: 1'b0, v1: 4'd1, win: 0, v: 15};
    tbl[5] = '{r0: 1'b1, v0: 4'd1,  r1: 1'b1, v1: 4'd6, win: 1, v: 6};
    tbl[6] = '{r0: 1'b1, v0: 4'd0,  r1: 1'b0, v1: 4'd8, win: 0, v: 0};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt_a", int'({a_gnt1, a_gnt0}), 0);
    chk("rst_done_a", int'({a_done1, a_done0}), 0);
    chk("rst_busy_a", int'(a_busy), 0);
    chk("rst_latch_dec_a", int'({a_latch, a_dec}), 0);
    chk("rst_cin_a", int'(a_cin), 0);
    chk("rst_busy_b", int'(b_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_req_busy", int'(a_busy | b_busy), 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Both requests held from reset: grants alternate 0,1,0.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; val0 = 4'd3; val1 = 4'd5;
    n = 0; ng = 0; nd = 0; val_changed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g[i] = -1; load_n[i] = -1; done_n[i] = -1; decs[i] = 0;
    end
    while (nd < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (a_latch && ng < 3) begin
        g[ng] = a_gnt1 ? 1 : 0;
        load_n[ng] = n;
        ng++;
      end
      if (ng > 0) decs[ng-1] += int'(a_dec);
      // Changing val1 while requester 1 counts down must not matter.
      if (ng == 2 && !val_changed) begin
        val1 = 4'd14;
        val_changed = 1'b1;
      end
      if ((a_done0 || a_done1) && nd < 3) begin
        done_n[nd] = n;
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_order0", g[0], 0);
    chk("alt_order1", g[1], 1);
    chk("alt_order2", g[2], 0);
    chk("alt_first_load", load_n[0], 1);
    chk("alt_done0_at", done_n[0], 6);
    chk("alt_idle_gap", load_n[1] - done_n[0], 2);
    chk("alt_lat1", done_n[1] - load_n[1], 2 + 5);
    chk("alt_lat2", done_n[2] - load_n[2], 2 + 3);
    chk("alt_decs0", decs[0], 3);
    chk("alt_decs1", decs[1], 5);
    chk("alt_decs2", decs[2], 3);
    for (int i = 0; i < 3; i++)
      $display("alt grant %0d: requester=%0d load@%0d done@%0d decs=%0d",
               i, g[i], load_n[i], done_n[i], decs[i]);

    // Reset in the middle of a countdown.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    req0 = 1'b1; val0 = 4'd9;
    n = 0; dec_a = 0;
    while (dec_a < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("mid_load_cin", int'(a_cin), 9);
        req0 = 1'b0;
      end
      dec_a += int'(a_dec);
    end
    chk("mid_dec_reached", dec_a, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", int'({a_gnt1, a_gnt0}), 0);
    chk("mid_rst_busy", int'(a_busy), 0);
    chk("mid_rst_latch_dec", int'({a_latch, a_dec}), 0);
    chk("mid_rst_cin", int'(a_cin), 0);
    chk("mid_rst_done", int'({a_done1, a_done0}), 0);
    chk("mid_cnt_kept", int'(a_cnt), 6);
    $display("mid-countdown reset: counter left at %0d", a_cnt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", int'({a_done1, a_done0}), 0);
    end
    rst = 1'b1;
    req1 = 1'b1; val1 = 4'd2;
    n = 0; nd5 = -1; dec_a = 0;
    while (nd5 < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("post_rst_gnt", int'({a_gnt1, a_gnt0}), 2);
        chk("post_rst_cin", int'(a_cin), 2);
        req1 = 1'b0;
      end
      dec_a += int'(a_dec);
      if (a_done0 || a_done1) begin
        nd5 = n;
        chk("post_rst_done_who", int'({a_done1, a_done0}), 2);
      end
    end
    chk("post_rst_latency", nd5, 5);
    chk("post_rst_decs", dec_a, 2);
    $display("post-reset grant: requester=1 value=2 done@%0d decs=%0d", nd5, dec_a);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
